serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor computing `d = a - b - bin` one bit per clock, LSB first, using the same per-bit sum/carry structure as the team's full adder with borrow in place of carry. It is the inverse-direction companion to the adder path. It serves area-constrained datapaths where a WIDTH-bit ripple subtractor is not wanted. Operands enter through a valid/ready handshake, and the result leaves through another, one operation in flight at a time.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH ≥ 2.

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands present
- `in_ready`  out  1  block can accept operands
- `a`  in  WIDTH  minuend
- `b`  in  WIDTH  subtrahend
- `bin`  in  1  borrow-in
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes the result
- `d`  out  WIDTH  difference, `a - b - bin` mod 2^WIDTH
- `bout`  out  1  borrow-out; 1 when unsigned `a < b + bin`
- `ovf`  out  1  signed (two's-complement) overflow
- `busy`  out  1  state is RUN

## Operation
- FSM states are IDLE, RUN and DONE.
  - `in_ready = (state == IDLE)`.
  - `busy = (state == RUN)`.
  - `out_valid = (state == DONE)`.
- IDLE:
  - On `in_valid & in_ready` at an edge, capture `a` and `b` into shift registers and `bin` into the borrow flop.
  - Clear bit counter `cnt` and the result register, then go to RUN.
  - `a`, `b` and `bin` are ignored at all other times.
- RUN, one bit per edge, LSB first:
  - Take `x = a_sh[0]`, `y = b_sh[0]`, `br` = borrow flop.
  - Difference bit: `x ^ y ^ br`. Shift it into the MSB of the result register (right shift).
  - Next borrow: `(~x & y) | (~(x ^ y) & br)`.
  - Shift `a_sh` and `b_sh` right by one.
  - Increment `cnt`.
  - When the edge processes `cnt == WIDTH-1`, go to DONE.
- Entering DONE:
  - `bout` takes the final borrow.
  - `ovf = (a[WIDTH-1] != b[WIDTH-1]) & (d[WIDTH-1] != a[WIDTH-1])`. Capture a copy of both operand MSBs at accept for this.
- DONE:
  - `d`, `bout` and `ovf` hold stable while `out_valid` is high.
  - On `out_ready` at an edge, go to IDLE.
- There is no overlap: a new operand is accepted only in IDLE. Dropping `in_valid` is irrelevant once the operands have been accepted.
- `cnt` width is `$clog2(WIDTH)`; it never wraps inside an operation.

## Timing
- Reset values, applied at the edge with `rst` high:
  - state = IDLE, so `in_ready = 1` from the following cycle.
  - `out_valid = 0`, `busy = 0`.
  - `d = 0`, `bout = 0`, `ovf = 0`.
  - `cnt = 0`, shift registers = 0.
- Reset has priority over every other event, including any handshake in the same cycle.
- Reset in RUN or DONE abandons the operation. No `out_valid` is produced for it.
- Latency: for an accept at edge k, bits are processed at edges k+1 … k+WIDTH, and `out_valid` is first high in the cycle after edge k+WIDTH.
- With `out_ready` held high, throughput is one result per WIDTH+2 cycles:
  - accept edge k;
  - DONE → IDLE at edge k+WIDTH+1;
  - next accept at edge k+WIDTH+2.
- `out_ready` low: the block stays in DONE indefinitely with outputs frozen, and `in_ready` stays 0 (backpressure).
- `d`, `bout` and `ovf` are registered.
  - Their values outside DONE are don't-care for consumers.
  - In practice they hold the last result until the next accept clears `d`.

## Test plan
- Reset, then WIDTH=8, a=0x5A, b=0x23, bin=0, `out_ready`=1 → `out_valid` first high 8 cycles after the accept edge; d=0x37, bout=0, ovf=0; `in_ready` back to 1 one cycle after DONE.
- a=0x00, b=0x01, bin=0 → d=0xFF, bout=1, ovf=0. Then a=0x10, b=0x0F, bin=1 → d=0x00, bout=0.
- Signed overflow:
  - a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF → d=0x80, bout=1, ovf=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new operands → d, bout and ovf stay stable, `in_ready`=0, and no new accept occurs. Releasing `out_ready` then produces the next operation's result, again WIDTH cycles after its own accept edge.
- Reset mid-RUN at bit 3 → the next cycle shows state IDLE, `busy`=0, `out_valid`=0, d=0. A fresh operation afterwards (a=0x01, b=0x01) gives d=0x00, bout=0 with correct latency.
- Randomized sweep of 1000 operand/bin triples at WIDTH=8 and WIDTH=13 with random `out_ready` stalls → d, bout and ovf match a reference model, and every accepted operation produces exactly one result.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;
   modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, d, bout, ovf);
   modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, d, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin one bit per clock, LSB first
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  s,
   output logic                busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, am_q, am_d, bm_q, bm_d;
   logic             x, y, diff, nb, last;
   assign s.in_ready  = state_q == IDLE;
   assign s.out_valid = state_q == DONE;
   assign busy        = state_q == RUN;
   assign s.d         = d_q;
   assign s.bout      = bout_q;
   assign s.ovf       = ovf_q;
   // Next-state: accept operands, step one full-subtractor bit per cycle, hold result until taken
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      am_d    = am_q;
      bm_d    = bm_q;
      x       = a_sh_q[0];
      y       = b_sh_q[0];
      diff    = x ^ y ^ br_q;
      nb      = (~x & y) | (~(x ^ y) & br_q);
      last    = cnt_q == CW'(WIDTH - 1);
      case (state_q)
         IDLE: if (s.in_valid) begin
            state_d = RUN;
            a_sh_d  = s.a;
            b_sh_d  = s.b;
            br_d    = s.bin;
            am_d    = s.a[WIDTH-1];
            bm_d    = s.b[WIDTH-1];
            cnt_d   = '0;
            d_d     = '0;
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_d    = {diff, d_q[WIDTH-1:1]};
            br_d   = nb;
            cnt_d  = last ? cnt_q : cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               bout_d  = nb;
               ovf_d   = (am_q != bm_q) & (diff != am_q);
            end
         end
         DONE: state_d = s.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // State register with synchronous reset taking priority over any handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         am_q    <= 1'b0;
         bm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         am_q    <= am_d;
         bm_q    <= bm_d;
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of the bit-serial subtractor at WIDTH 8 and 13
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy8, busy13;
   int   vectors = 0;
   int   miscompares = 0;
   serial_subtractor_if #(.WIDTH(8))  i8 ();
   serial_subtractor_if #(.WIDTH(13)) i13 ();
   serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .s(i8),  .busy(busy8));
   serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .s(i13), .busy(busy13));
   // Free-running clock
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic run_op(input string name, input logic [7:0] ra, input logic [7:0] rb, input logic rbin,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int t;
      i8.out_ready = 1'b1;
      i8.a = ra;
      i8.b = rb;
      i8.bin = rbin;
      i8.in_valid = 1'b1;
      t = 0;
      while (!i8.in_ready && t < 50) begin
         step;
         t++;
      end
      vectors++;
      if (i8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready timeout: got %b want 1", name, i8.in_ready);
      end
      step;
      i8.in_valid = 1'b0;
      vectors++;
      if (busy8 !== 1'b1) begin
         miscompares++;
         $display("FAIL %s busy after accept: got %b want 1", name, busy8);
      end
      repeat (7) step;
      vectors++;
      if (i8.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s early out_valid: got %b want 0", name, i8.out_valid);
      end
      step;
      vectors++;
      if (i8.out_valid !== 1'b1 || i8.d !== ed || i8.bout !== eb || i8.ovf !== eo) begin
         miscompares++;
         $display("FAIL %s result: got v=%b d=%h bout=%b ovf=%b want v=1 d=%h bout=%b ovf=%b",
                  name, i8.out_valid, i8.d, i8.bout, i8.ovf, ed, eb, eo);
      end
      step;
      vectors++;
      if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s return to idle: got in_ready=%b out_valid=%b want 1 0", name, i8.in_ready, i8.out_valid);
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) step;
      rst = 1'b0;
      vectors++;
      if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0 || busy8 !== 1'b0 || i8.d !== 8'h00 ||
          i8.bout !== 1'b0 || i8.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset8: got rdy=%b v=%b busy=%b d=%h bout=%b ovf=%b want 1 0 0 00 0 0",
                  i8.in_ready, i8.out_valid, busy8, i8.d, i8.bout, i8.ovf);
      end
      vectors++;
      if (i13.in_ready !== 1'b1 || i13.out_valid !== 1'b0 || busy13 !== 1'b0 || i13.d !== 13'h0) begin
         miscompares++;
         $display("FAIL reset13: got rdy=%b v=%b busy=%b d=%h want 1 0 0 0", i13.in_ready, i13.out_valid, busy13, i13.d);
      end
   endtask
   task automatic test_basic;
      run_op("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
   endtask
   task automatic test_borrow;
      run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("borrow_in", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic test_overflow;
      run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
   endtask
   task automatic test_backpressure;
      i8.out_ready = 1'b0;
      i8.a = 8'h33;
      i8.b = 8'h11;
      i8.bin = 1'b0;
      i8.in_valid = 1'b1;
      step;
      i8.in_valid = 1'b0;
      repeat (8) step;
      i8.a = 8'h44;
      i8.b = 8'h45;
      i8.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (i8.out_valid !== 1'b1 || i8.in_ready !== 1'b0 || i8.d !== 8'h22 || i8.bout !== 1'b0 || i8.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure hold %0d: got v=%b rdy=%b d=%h bout=%b ovf=%b want 1 0 22 0 0",
                     i, i8.out_valid, i8.in_ready, i8.d, i8.bout, i8.ovf);
         end
         step;
      end
      i8.out_ready = 1'b1;
      step;
      vectors++;
      if (i8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure release: got in_ready=%b want 1", i8.in_ready);
      end
      step;
      i8.in_valid = 1'b0;
      repeat (7) step;
      vectors++;
      if (i8.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure next early: got out_valid=%b want 0", i8.out_valid);
      end
      step;
      vectors++;
      if (i8.out_valid !== 1'b1 || i8.d !== 8'hFF || i8.bout !== 1'b1 || i8.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure next result: got v=%b d=%h bout=%b ovf=%b want 1 ff 1 0",
                  i8.out_valid, i8.d, i8.bout, i8.ovf);
      end
      step;
   endtask
   task automatic test_reset_mid_run;
      i8.out_ready = 1'b1;
      i8.a = 8'hFF;
      i8.b = 8'h00;
      i8.bin = 1'b0;
      i8.in_valid = 1'b1;
      step;
      i8.in_valid = 1'b0;
      repeat (3) step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      vectors++;
      if (i8.in_ready !== 1'b1 || busy8 !== 1'b0 || i8.out_valid !== 1'b0 || i8.d !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_mid_run: got rdy=%b busy=%b v=%b d=%h want 1 0 0 00", i8.in_ready, busy8, i8.out_valid, i8.d);
      end
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (i8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run abandoned result: got out_valid=%b want 0 at cycle %0d", i8.out_valid, i);
         end
         step;
      end
      run_op("after_reset", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic test_random8;
      logic [7:0] ra, rb;
      logic       rbin, eo;
      logic [8:0] full;
      int         sd, t;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rbin = 1'($urandom_range(0, 1));
         full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
         sd = $signed(ra) - $signed(rb) - int'(rbin);
         eo = (sd < -128) || (sd > 127);
         i8.out_ready = 1'b0;
         i8.a = ra;
         i8.b = rb;
         i8.bin = rbin;
         i8.in_valid = 1'b1;
         step;
         i8.in_valid = 1'b0;
         t = 0;
         while (!i8.out_valid && t < 40) begin
            step;
            t++;
         end
         repeat ($urandom_range(0, 3)) step;
         vectors++;
         if (t != 8 || i8.out_valid !== 1'b1 || i8.d !== full[7:0] || i8.bout !== full[8] || i8.ovf !== eo) begin
            miscompares++;
            $display("FAIL rand8 %0d a=%h b=%h bin=%b: got lat=%0d v=%b d=%h bout=%b ovf=%b want lat=8 v=1 d=%h bout=%b ovf=%b",
                     i, ra, rb, rbin, t, i8.out_valid, i8.d, i8.bout, i8.ovf, full[7:0], full[8], eo);
         end
         i8.out_ready = 1'b1;
         step;
         vectors++;
         if (i8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand8 %0d single result: got out_valid=%b want 0", i, i8.out_valid);
         end
      end
   endtask
   task automatic test_random13;
      logic [12:0] ra, rb;
      logic        rbin, eo;
      logic [13:0] full;
      int          sd, t;
      for (int i = 0; i < 1000; i++) begin
         ra = 13'($urandom);
         rb = 13'($urandom);
         rbin = 1'($urandom_range(0, 1));
         full = {1'b0, ra} - {1'b0, rb} - {13'b0, rbin};
         sd = $signed(ra) - $signed(rb) - int'(rbin);
         eo = (sd < -4096) || (sd > 4095);
         i13.out_ready = 1'b0;
         i13.a = ra;
         i13.b = rb;
         i13.bin = rbin;
         i13.in_valid = 1'b1;
         step;
         i13.in_valid = 1'b0;
         t = 0;
         while (!i13.out_valid && t < 40) begin
            step;
            t++;
         end
         repeat ($urandom_range(0, 3)) step;
         vectors++;
         if (t != 13 || i13.out_valid !== 1'b1 || i13.d !== full[12:0] || i13.bout !== full[13] || i13.ovf !== eo) begin
            miscompares++;
            $display("FAIL rand13 %0d a=%h b=%h bin=%b: got lat=%0d v=%b d=%h bout=%b ovf=%b want lat=13 v=1 d=%h bout=%b ovf=%b",
                     i, ra, rb, rbin, t, i13.out_valid, i13.d, i13.bout, i13.ovf, full[12:0], full[13], eo);
         end
         i13.out_ready = 1'b1;
         step;
         vectors++;
         if (i13.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand13 %0d single result: got out_valid=%b want 0", i, i13.out_valid);
         end
      end
   endtask
   // Test sequence
   initial begin
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b0;
      i8.a = '0;
      i8.b = '0;
      i8.bin = 1'b0;
      i13.in_valid = 1'b0;
      i13.out_ready = 1'b0;
      i13.a = '0;
      i13.b = '0;
      i13.bin = 1'b0;
      test_reset;
      test_basic;
      test_borrow;
      test_overflow;
      test_backpressure;
      test_reset_mid_run;
      test_random8;
      test_random13;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
